// File: rtl/mul_arb.sv
// Round-robin arbiter/sequencer for the shared 8x8 shift-add multiplier; two clients, one mul.
// Optional watchdog on the multiplier handshake is enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arb (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        vld,
  output logic        vld_id,
  output logic [16:0] res,
  output logic        err,
  output logic [7:0]  m_a,
  output logic [7:0]  m_b,
  output logic        m_start,
  input  logic [16:0] m_o,
  input  logic        m_fin
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic        gnt0;
    logic        gnt1;
    logic        vld;
    logic        vld_id;
    logic        err;
    logic        m_start;
    logic [16:0] res;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic        cur;
    logic        last;
  } regs_t;

  state_t state_q, state_d;
  regs_t  r_q, r_d;
  logic   any_req, pick1, tmo;

  assign any_req = req0 | req1;
  // On contention the client that was not served last wins.
  assign pick1   = req1 & (~req0 | ~r_q.last);

`ifdef MUL_ARB_TIMEOUT_EN
  logic [3:0] wdog_q;
  logic [3:0] wdog_inc;

  assign wdog_inc = wdog_q + 4'd1;
  assign tmo      = (state_q == S_WAIT) && (wdog_inc == 4'd12);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)                 wdog_q <= '0;
    else if (state_q == S_IDLE) wdog_q <= '0;
    else                        wdog_q <= wdog_inc;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      r_q.last   <= 1'b1;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (any_req)       state_d = S_WAIT;
      S_WAIT: if (m_fin || tmo)  state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    r_d         = r_q;
    r_d.gnt0    = 1'b0;
    r_d.gnt1    = 1'b0;
    r_d.vld     = 1'b0;
    r_d.err     = 1'b0;
    r_d.m_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          r_d.m_start = 1'b1;
          r_d.cur     = pick1;
          r_d.last    = pick1;
          if (pick1) begin
            r_d.gnt1 = 1'b1;
            r_d.m_a  = a1;
            r_d.m_b  = b1;
          end else begin
            r_d.gnt0 = 1'b1;
            r_d.m_a  = a0;
            r_d.m_b  = b0;
          end
        end
      end
      S_WAIT: begin
        // A finish on the watchdog's last cycle still completes normally.
        if (m_fin) begin
          r_d.res    = m_o;
          r_d.vld_id = r_q.cur;
          r_d.vld    = 1'b1;
        end else if (tmo) begin
          r_d.err    = 1'b1;
          r_d.vld_id = r_q.cur;
        end
      end
      default: ;
    endcase
  end

  assign gnt0    = r_q.gnt0;
  assign gnt1    = r_q.gnt1;
  assign vld     = r_q.vld;
  assign vld_id  = r_q.vld_id;
  assign res     = r_q.res;
  assign err     = r_q.err;
  assign m_a     = r_q.m_a;
  assign m_b     = r_q.m_b;
  assign m_start = r_q.m_start;

endmodule
